hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It decides when D must hold and E must take a bubble, using Tuse/Tnew register hazards and the multiply/divide unit's busy window. It drives the PC/F-D enables and the D/E clear, and tracks the M-stage destination and Tnew internally. It also owns the mult/div busy countdown so the HI/LO unit needs no separate sequencer.

Parameters:
MULT_CYC, 5, busy cycles after a mult/multu start
DIV_CYC, 10, busy cycles after a div/divu start
CNT_W, 4, width of busy counter; must hold max(MULT_CYC, DIV_CYC)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
D_rs  in  5  rs field of instruction in D
D_rt  in  5  rt field of instruction in D
D_Tuse_rs  in  2  cycles until rs is needed (0, 1; 3 = not read)
D_Tuse_rt  in  2  same for rt
D_is_md  in  1  D instruction uses the HI/LO unit (mult/multu/div/divu/mfhi/mflo/mthi/mtlo)
E_A3  in  5  destination register in E
E_Tnew  in  2  Tnew of instruction in E (from D/E register)
E_md_start  in  1  E holds mult/multu/div/divu this cycle
E_md_is_div  in  1  1 = div/divu, 0 = mult/multu; valid with E_md_start
PC_en  out  1  PC write enable
FD_en  out  1  F/D register enable
DE_clr  out  1  D/E register clear (bubble insert)
md_busy  out  1  mult/div unit busy (counter nonzero)
M_A3_q  out  5  internally tracked M destination
M_Tnew_q  out  2  internally tracked M Tnew
stall_cnt  out  32  number of stall cycles since reset, saturating

Behaviour:
- Reset values: M_A3_q = 0, M_Tnew_q = 0, busy counter = 0, md_busy = 0, stall_cnt = 0. Combinational outputs follow: PC_en = FD_en = 1, DE_clr = 0.
- M tracking, every clock with no enable: M_A3_q <= E_A3; M_Tnew_q <= (E_Tnew == 0) ? 0 : E_Tnew - 1. E to M always advances, because a bubble in E carries A3 = 0 and Tnew = 0.
- rs hazard (combinational): D_rs != 0 and either:
  - E_A3 == D_rs and E_Tnew > D_Tuse_rs, or
  - M_A3_q == D_rs and M_Tnew_q > D_Tuse_rs.
- rt hazard: same rule using D_rt and D_Tuse_rt.
- Tuse = 3 never stalls, since Tnew ≤ 2. W stage never causes a stall; its values are forwarded.
- md hazard: D_is_md and (E_md_start or md_busy).
- stall = rs hazard | rt hazard | md hazard. PC_en = FD_en = !stall; DE_clr = stall. Pure combinational, zero-cycle latency.
- Busy counter:
  - On E_md_start with counter == 0: load DIV_CYC if E_md_is_div, else MULT_CYC.
  - Otherwise, if counter != 0, decrement by 1.
  - md_busy = (counter != 0).
  - Total HI/LO blocking window = 1 start cycle + N busy cycles.
- E_md_start while counter != 0 cannot occur legally, because D is stalled. If it does, it is ignored (no reload) and the countdown continues.
- stall_cnt increments on each clock where stall = 1; it holds at 0xFFFFFFFF.
- Reset mid-operation clears the counter and the M tracking immediately at the clock edge. The stall condition re-evaluates from cleared state in the next cycle.
- Register $0 never causes a hazard, even if E_A3 or M_A3_q is 0 with nonzero Tnew.

Decomposition:
- Shared constants file: Tuse encodings (TUSE_0, TUSE_1, TUSE_NONE = 2'b11) and the MULT_CYC/DIV_CYC defaults, next to the existing opcode/funct defines.
- One natural sub-module: md_busy_counter (load/decrement/busy flag). Hazard compare and M tracking stay in the top module.

Test Plan:
- lw $1 in E (E_A3 = 1, E_Tnew = 2), D reads $1 with Tuse_rs = 0 -> stall cycle 1. Next cycle M_A3_q = 1, M_Tnew_q = 1 -> stall again. Cycle 3 -> no stall; stall_cnt = 2.
- add $2 in E (Tnew = 1), D beq on $2 (Tuse = 0) -> exactly 1 stall cycle. Same with D add (Tuse = 1) -> 0 stall cycles.
- D rs = 0, E_A3 = 0, E_Tnew = 2, Tuse = 0 -> no stall, PC_en = 1, DE_clr = 0.
- E_md_start = 1, E_md_is_div = 0, D mflo -> stall in start cycle plus 5 busy cycles (6 total). md_busy falls after 5 clocks. Repeat with div -> 11 total.
- Start div, then assert reset after 3 busy cycles -> next cycle md_busy = 0, stall = 0, stall_cnt = 0, M_A3_q = 0.
- Mult in flight, D holds a non-md add with no register hazard -> no stall while md_busy = 1.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
// Shared constants for the pipeline control slice: opcode/funct encodings,
// Tuse encodings, default mult/div latencies and the register hazard helper.
// ---------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

    // Primary opcodes used by the pipeline decode
    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00,
        OP_BEQ     = 6'h04,
        OP_ADDI    = 6'h08,
        OP_LW      = 6'h23,
        OP_SW      = 6'h2b
    } opcode_e;

    // SPECIAL funct codes that touch the HI/LO unit
    typedef enum logic [5:0] {
        FN_MFHI  = 6'h10,
        FN_MTHI  = 6'h11,
        FN_MFLO  = 6'h12,
        FN_MTLO  = 6'h13,
        FN_MULT  = 6'h18,
        FN_MULTU = 6'h19,
        FN_DIV   = 6'h1a,
        FN_DIVU  = 6'h1b
    } funct_e;

    // Tuse encodings: cycles until D needs the operand; NONE = not read
    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_NONE = 2'b11;

    // Default busy windows of the multiply/divide unit
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // A source register conflicts with a producer when the producer writes
    // it and its result will not be ready by the time the consumer needs it.
    // $0 is hard-wired, so it never conflicts.
    function automatic logic reg_hazard(input logic [4:0] src,
                                        input logic [1:0] tuse,
                                        input logic [4:0] dst,
                                        input logic [1:0] tnew);
        return (src != 5'd0) && (dst == src) && (tnew > tuse);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_md_busy_counter
// Busy countdown for the HI/LO multiply/divide unit.
//   clk, reset   : clock, synchronous active-high reset
//   md_start     : mult/multu/div/divu in E this cycle
//   md_is_div    : 1 = divide latency, 0 = multiply latency
//   md_busy      : counter nonzero
// A start while already busy is ignored; the running countdown continues.
// ---------------------------------------------------------------------------
module hazard_stall_ctrl_md_busy_counter #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_is_div,
    output logic md_busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (md_start && (cnt_reg == '0)) begin
            cnt_reg <= md_is_div ? DIV_LOAD : MULT_LOAD;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_ONE;
        end
    end

    assign md_busy = (cnt_reg != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
// Stall/flush controller for the 5-stage pipeline. Holds PC and F/D and
// clears D/E whenever the instruction in D cannot proceed: a register it
// reads is produced too late by E or M (Tuse/Tnew), or it uses HI/LO while
// the multiply/divide unit is starting or busy.
//   clk, reset          : clock, synchronous active-high reset
//   D_rs/D_rt           : source registers of D
//   D_Tuse_rs/D_Tuse_rt : cycles until each source is needed (3 = unused)
//   D_is_md             : D uses the HI/LO unit
//   E_A3/E_Tnew         : destination and Tnew of the instruction in E
//   E_md_start/_is_div  : mult/div launching from E, and which kind
//   PC_en/FD_en/DE_clr  : pipeline enables and bubble insert
//   md_busy             : mult/div unit busy
//   M_A3_q/M_Tnew_q     : tracked M-stage destination and Tnew
//   stall_cnt           : saturating count of stall cycles since reset
// ---------------------------------------------------------------------------
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_A3,
    input  logic [1:0]  E_Tnew,
    input  logic        E_md_start,
    input  logic        E_md_is_div,
    output logic        PC_en,
    output logic        FD_en,
    output logic        DE_clr,
    output logic        md_busy,
    output logic [4:0]  M_A3_q,
    output logic [1:0]  M_Tnew_q,
    output logic [31:0] stall_cnt
);

    logic [4:0]  m_a3_reg;
    logic [1:0]  m_tnew_reg;
    logic [1:0]  m_tnew_next;
    logic [31:0] stall_cnt_reg;
    logic        rs_hazard;
    logic        rt_hazard;
    logic        md_hazard;
    logic        stall;

    hazard_stall_ctrl_md_busy_counter #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_busy_counter (
        .clk       (clk),
        .reset     (reset),
        .md_start  (E_md_start),
        .md_is_div (E_md_is_div),
        .md_busy   (md_busy)
    );

    // W is never checked: anything that reached W is forwarded.
    assign rs_hazard = reg_hazard(D_rs, D_Tuse_rs, E_A3, E_Tnew)
                     | reg_hazard(D_rs, D_Tuse_rs, m_a3_reg, m_tnew_reg);
    assign rt_hazard = reg_hazard(D_rt, D_Tuse_rt, E_A3, E_Tnew)
                     | reg_hazard(D_rt, D_Tuse_rt, m_a3_reg, m_tnew_reg);

    // The start cycle itself blocks too, since the counter loads at its end.
    assign md_hazard = D_is_md & (E_md_start | md_busy);

    assign stall  = rs_hazard | rt_hazard | md_hazard;
    assign PC_en  = ~stall;
    assign FD_en  = ~stall;
    assign DE_clr = stall;

    // E always advances into M; a bubble in E already carries A3 = 0, Tnew = 0.
    assign m_tnew_next = (E_Tnew == 2'd0) ? 2'd0 : (E_Tnew - 2'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            m_a3_reg      <= '0;
            m_tnew_reg    <= '0;
            stall_cnt_reg <= '0;
        end else begin
            m_a3_reg   <= E_A3;
            m_tnew_reg <= m_tnew_next;
            if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

    assign M_A3_q    = m_a3_reg;
    assign M_Tnew_q  = m_tnew_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Scenario tasks drive one pipeline cycle at a time; each driven cycle pushes
// its expected outputs to a scoreboard queue, which the task pops and
// compares at the following falling edge.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_A3;
    logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew;
    logic        D_is_md, E_md_start, E_md_is_div;
    logic        PC_en, FD_en, DE_clr, md_busy;
    logic [4:0]  M_A3_q;
    logic [1:0]  M_Tnew_q;
    logic [31:0] stall_cnt;

    hazard_stall_ctrl #(
        .MULT_CYC (5),
        .DIV_CYC  (10),
        .CNT_W    (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .D_rs        (D_rs),
        .D_rt        (D_rt),
        .D_Tuse_rs   (D_Tuse_rs),
        .D_Tuse_rt   (D_Tuse_rt),
        .D_is_md     (D_is_md),
        .E_A3        (E_A3),
        .E_Tnew      (E_Tnew),
        .E_md_start  (E_md_start),
        .E_md_is_div (E_md_is_div),
        .PC_en       (PC_en),
        .FD_en       (FD_en),
        .DE_clr      (DE_clr),
        .md_busy     (md_busy),
        .M_A3_q      (M_A3_q),
        .M_Tnew_q    (M_Tnew_q),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [1:0] tu_rs;
        logic [4:0] rt;
        logic [1:0] tu_rt;
        logic       is_md;
        logic [4:0] e_a3;
        logic [1:0] e_tnew;
        logic       start;
        logic       is_div;
        logic       stall;
        logic       busy;
    } step_t;

    typedef struct {
        string       name;
        logic        stall;
        logic        busy;
        logic [4:0]  m_a3;
        logic [1:0]  m_tnew;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          passes = 0;
    logic [4:0]  mdl_a3;
    logic [1:0]  mdl_tnew;
    logic [31:0] mdl_cnt;

    function automatic step_t mk(string n, logic [4:0] rs, logic [1:0] tu_rs,
                                 logic [4:0] rt, logic [1:0] tu_rt, logic is_md,
                                 logic [4:0] e_a3, logic [1:0] e_tnew,
                                 logic start, logic is_div, logic stall, logic busy);
        step_t s;
        s.name = n; s.rs = rs; s.tu_rs = tu_rs; s.rt = rt; s.tu_rt = tu_rt;
        s.is_md = is_md; s.e_a3 = e_a3; s.e_tnew = e_tnew; s.start = start;
        s.is_div = is_div; s.stall = stall; s.busy = busy;
        return s;
    endfunction

    function automatic step_t idle(string n);
        return mk(n, 5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic set_idle_inputs();
        D_rs = 5'd0; D_rt = 5'd0; D_Tuse_rs = TUSE_NONE; D_Tuse_rt = TUSE_NONE;
        D_is_md = 1'b0; E_A3 = 5'd0; E_Tnew = 2'd0; E_md_start = 1'b0; E_md_is_div = 1'b0;
    endtask

    // Drive one cycle and queue what should be visible at the next falling edge.
    task automatic drive_step(input step_t s);
        exp_t e;
        @(posedge clk); #1;
        D_rs = s.rs; D_Tuse_rs = s.tu_rs; D_rt = s.rt; D_Tuse_rt = s.tu_rt;
        D_is_md = s.is_md; E_A3 = s.e_a3; E_Tnew = s.e_tnew;
        E_md_start = s.start; E_md_is_div = s.is_div;
        e.name = s.name; e.stall = s.stall; e.busy = s.busy;
        e.m_a3 = mdl_a3; e.m_tnew = mdl_tnew; e.cnt = mdl_cnt;
        exp_q.push_back(e);
        mdl_a3   = s.e_a3;
        mdl_tnew = (s.e_tnew == 2'd0) ? 2'd0 : s.e_tnew - 2'd1;
        if (s.stall && mdl_cnt != 32'hFFFF_FFFF) mdl_cnt = mdl_cnt + 32'd1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        set_idle_inputs();
        @(posedge clk); #1;
        reset = 1'b0;
        mdl_a3 = 5'd0; mdl_tnew = 2'd0; mdl_cnt = 32'd0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        set_idle_inputs();
        repeat (2) @(posedge clk);
        e.name = "reset"; e.stall = 1'b0; e.busy = 1'b0; e.m_a3 = 5'd0; e.m_tnew = 2'd0; e.cnt = 32'd0;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        $display("%-12s pc=%b fd=%b clr=%b busy=%b m=%0d/%0d cnt=%0d", e.name, PC_en, FD_en, DE_clr, md_busy, M_A3_q, M_Tnew_q, stall_cnt);
        checks++; if ({PC_en, FD_en, DE_clr} !== {~e.stall, ~e.stall, e.stall}) $display("FAIL %s enables: got %b%b%b expected stall=%b", e.name, PC_en, FD_en, DE_clr, e.stall); else passes++;
        checks++; if (md_busy !== e.busy) $display("FAIL %s md_busy: got %b expected %b", e.name, md_busy, e.busy); else passes++;
        checks++; if ({M_A3_q, M_Tnew_q} !== {e.m_a3, e.m_tnew}) $display("FAIL %s M track: got %0d/%0d expected %0d/%0d", e.name, M_A3_q, M_Tnew_q, e.m_a3, e.m_tnew); else passes++;
        checks++; if (stall_cnt !== e.cnt) $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.cnt); else passes++;
        @(posedge clk); #1;
        reset = 1'b0;
        mdl_a3 = 5'd0; mdl_tnew = 2'd0; mdl_cnt = 32'd0;
    endtask

    task automatic test_load_use();
        step_t st[$];
        exp_t  e;
        st.push_back(mk("lw_in_e", 5'd1, TUSE_0, 5'd0, TUSE_NONE, 1'b0, 5'd1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0));
        st.push_back(mk("lw_in_m", 5'd1, TUSE_0, 5'd0, TUSE_NONE, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        st.push_back(mk("lw_release", 5'd1, TUSE_0, 5'd0, TUSE_NONE, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        foreach (st[i]) begin
            drive_step(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            $display("%-12s pc=%b fd=%b clr=%b busy=%b m=%0d/%0d cnt=%0d", e.name, PC_en, FD_en, DE_clr, md_busy, M_A3_q, M_Tnew_q, stall_cnt);
            checks++; if ({PC_en, FD_en, DE_clr} !== {~e.stall, ~e.stall, e.stall}) $display("FAIL %s enables: got %b%b%b expected stall=%b", e.name, PC_en, FD_en, DE_clr, e.stall); else passes++;
            checks++; if ({M_A3_q, M_Tnew_q} !== {e.m_a3, e.m_tnew}) $display("FAIL %s M track: got %0d/%0d expected %0d/%0d", e.name, M_A3_q, M_Tnew_q, e.m_a3, e.m_tnew); else passes++;
            checks++; if (stall_cnt !== e.cnt) $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.cnt); else passes++;
        end
        // Two stall cycles so far since reset.
        @(posedge clk); #1;
        checks++; if (stall_cnt !== 32'd2) $display("FAIL lw_total stall_cnt: got %0d expected 2", stall_cnt); else passes++;
    endtask

    task automatic test_alu_forward();
        step_t st[$];
        exp_t  e;
        st.push_back(idle("alu_flush"));
        st.push_back(mk("beq_e", 5'd2, TUSE_0, 5'd0, TUSE_NONE, 1'b0, 5'd2, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0));
        st.push_back(mk("beq_m", 5'd2, TUSE_0, 5'd0, TUSE_NONE, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        st.push_back(mk("add_e", 5'd2, TUSE_1, 5'd0, TUSE_NONE, 1'b0, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0));
        st.push_back(mk("add_m", 5'd2, TUSE_1, 5'd0, TUSE_NONE, 1'b0, 5'd7, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        st.push_back(mk("rt_e", 5'd0, TUSE_NONE, 5'd3, TUSE_0, 1'b0, 5'd3, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0));
        st.push_back(mk("rt_m", 5'd0, TUSE_NONE, 5'd3, TUSE_0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        st.push_back(mk("rt_release", 5'd0, TUSE_NONE, 5'd3, TUSE_0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        st.push_back(mk("tu1_e", 5'd6, TUSE_1, 5'd0, TUSE_NONE, 1'b0, 5'd6, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0));
        st.push_back(mk("tu1_m", 5'd6, TUSE_1, 5'd0, TUSE_NONE, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        st.push_back(mk("tuse_none", 5'd4, TUSE_NONE, 5'd4, TUSE_NONE, 1'b0, 5'd4, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        foreach (st[i]) begin
            drive_step(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            $display("%-12s pc=%b fd=%b clr=%b busy=%b m=%0d/%0d cnt=%0d", e.name, PC_en, FD_en, DE_clr, md_busy, M_A3_q, M_Tnew_q, stall_cnt);
            checks++; if ({PC_en, FD_en, DE_clr} !== {~e.stall, ~e.stall, e.stall}) $display("FAIL %s enables: got %b%b%b expected stall=%b", e.name, PC_en, FD_en, DE_clr, e.stall); else passes++;
            checks++; if ({M_A3_q, M_Tnew_q} !== {e.m_a3, e.m_tnew}) $display("FAIL %s M track: got %0d/%0d expected %0d/%0d", e.name, M_A3_q, M_Tnew_q, e.m_a3, e.m_tnew); else passes++;
            checks++; if (stall_cnt !== e.cnt) $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.cnt); else passes++;
        end
    endtask

    task automatic test_zero_reg();
        step_t st[$];
        exp_t  e;
        st.push_back(idle("zero_flush"));
        st.push_back(mk("zero_e", 5'd0, TUSE_0, 5'd0, TUSE_0, 1'b0, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        st.push_back(mk("zero_m", 5'd0, TUSE_0, 5'd0, TUSE_0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        foreach (st[i]) begin
            drive_step(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            $display("%-12s pc=%b fd=%b clr=%b busy=%b m=%0d/%0d cnt=%0d", e.name, PC_en, FD_en, DE_clr, md_busy, M_A3_q, M_Tnew_q, stall_cnt);
            checks++; if ({PC_en, FD_en, DE_clr} !== {~e.stall, ~e.stall, e.stall}) $display("FAIL %s enables: got %b%b%b expected stall=%b", e.name, PC_en, FD_en, DE_clr, e.stall); else passes++;
            checks++; if ({M_A3_q, M_Tnew_q} !== {e.m_a3, e.m_tnew}) $display("FAIL %s M track: got %0d/%0d expected %0d/%0d", e.name, M_A3_q, M_Tnew_q, e.m_a3, e.m_tnew); else passes++;
        end
    endtask

    // D holds mflo behind a mult/div: stalls for the start cycle plus n busy cycles.
    task automatic test_md_stall(input logic is_div, input int n);
        step_t st[$];
        exp_t  e;
        st.push_back(idle("md_flush"));
        st.push_back(mk(is_div ? "div_start" : "mult_start", 5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 1'b1, 5'd0, 2'd0, 1'b1, is_div, 1'b1, 1'b0));
        for (int k = 0; k < n; k++)
            st.push_back(mk(is_div ? "div_busy" : "mult_busy", 5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 1'b1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1));
        st.push_back(mk(is_div ? "div_done" : "mult_done", 5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 1'b1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        foreach (st[i]) begin
            drive_step(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            $display("%-12s pc=%b fd=%b clr=%b busy=%b m=%0d/%0d cnt=%0d", e.name, PC_en, FD_en, DE_clr, md_busy, M_A3_q, M_Tnew_q, stall_cnt);
            checks++; if ({PC_en, FD_en, DE_clr} !== {~e.stall, ~e.stall, e.stall}) $display("FAIL %s enables: got %b%b%b expected stall=%b", e.name, PC_en, FD_en, DE_clr, e.stall); else passes++;
            checks++; if (md_busy !== e.busy) $display("FAIL %s md_busy: got %b expected %b", e.name, md_busy, e.busy); else passes++;
            checks++; if (stall_cnt !== e.cnt) $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.cnt); else passes++;
        end
    endtask

    // Non-HI/LO work proceeds under a busy mult; a stray start while busy
    // must not reload the counter (mult window still ends after 5 cycles).
    task automatic test_md_nonmd();
        step_t st[$];
        exp_t  e;
        st.push_back(idle("nm_flush"));
        st.push_back(mk("nm_start", 5'd5, TUSE_1, 5'd0, TUSE_NONE, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        st.push_back(mk("nm_stray", 5'd5, TUSE_1, 5'd0, TUSE_NONE, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1));
        for (int k = 0; k < 4; k++)
            st.push_back(mk("nm_busy", 5'd5, TUSE_1, 5'd0, TUSE_NONE, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        st.push_back(mk("nm_mflo", 5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 1'b1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        foreach (st[i]) begin
            drive_step(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            $display("%-12s pc=%b fd=%b clr=%b busy=%b m=%0d/%0d cnt=%0d", e.name, PC_en, FD_en, DE_clr, md_busy, M_A3_q, M_Tnew_q, stall_cnt);
            checks++; if ({PC_en, FD_en, DE_clr} !== {~e.stall, ~e.stall, e.stall}) $display("FAIL %s enables: got %b%b%b expected stall=%b", e.name, PC_en, FD_en, DE_clr, e.stall); else passes++;
            checks++; if (md_busy !== e.busy) $display("FAIL %s md_busy: got %b expected %b", e.name, md_busy, e.busy); else passes++;
        end
    endtask

    task automatic test_reset_mid_div();
        step_t st[$];
        exp_t  e;
        st.push_back(mk("rd_start", 5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 1'b1, 5'd9, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0));
        for (int k = 0; k < 3; k++)
            st.push_back(mk("rd_busy", 5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 1'b1, 5'd9, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1));
        foreach (st[i]) begin
            drive_step(st[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            $display("%-12s pc=%b fd=%b clr=%b busy=%b m=%0d/%0d cnt=%0d", e.name, PC_en, FD_en, DE_clr, md_busy, M_A3_q, M_Tnew_q, stall_cnt);
            checks++; if ({PC_en, FD_en, DE_clr} !== {~e.stall, ~e.stall, e.stall}) $display("FAIL %s enables: got %b%b%b expected stall=%b", e.name, PC_en, FD_en, DE_clr, e.stall); else passes++;
            checks++; if (md_busy !== e.busy) $display("FAIL %s md_busy: got %b expected %b", e.name, md_busy, e.busy); else passes++;
        end
        do_reset();
        drive_step(mk("rd_after", 5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 1'b1, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        e = exp_q.pop_front();
        $display("%-12s pc=%b fd=%b clr=%b busy=%b m=%0d/%0d cnt=%0d", e.name, PC_en, FD_en, DE_clr, md_busy, M_A3_q, M_Tnew_q, stall_cnt);
        checks++; if ({PC_en, FD_en, DE_clr} !== {~e.stall, ~e.stall, e.stall}) $display("FAIL %s enables: got %b%b%b expected stall=%b", e.name, PC_en, FD_en, DE_clr, e.stall); else passes++;
        checks++; if (md_busy !== e.busy) $display("FAIL %s md_busy: got %b expected %b", e.name, md_busy, e.busy); else passes++;
        checks++; if ({M_A3_q, M_Tnew_q} !== {e.m_a3, e.m_tnew}) $display("FAIL %s M track: got %0d/%0d expected %0d/%0d", e.name, M_A3_q, M_Tnew_q, e.m_a3, e.m_tnew); else passes++;
        checks++; if (stall_cnt !== e.cnt) $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, stall_cnt, e.cnt); else passes++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passes, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        mdl_a3 = 5'd0; mdl_tnew = 2'd0; mdl_cnt = 32'd0;
        test_reset();
        test_load_use();
        test_alu_forward();
        test_zero_reg();
        test_md_stall(1'b0, 5);
        test_md_stall(1'b1, 10);
        test_md_nonmd();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
